serial_add_ctrl: RTL and testbench

- Bit-serial adder controller. It sequences one full-adder cell over WIDTH clock cycles, LSB first, to add two WIDTH-bit operands with carry-in.
- A registered carry flip-flop links successive bits. The block trades latency for area versus a ripple array.
- It sits between a requester (start/done handshake) and the shared 1-bit full_adder datapath cell.

---
 rtl/serial_add_ctrl_pkg.sv | 14 +
 rtl/serial_add_ctrl_if.sv | 26 ++
 rtl/serial_add_ctrl_fa.sv | 14 +
 rtl/serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_serial_add_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl shared types.
// FSM encoding and counter-width helper.
package serial_add_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int cnt_w(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl request/result bundle.
// master drives operands, slave returns the sum.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Shared 1-bit full-adder datapath cell.
// Purely combinational.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped
// over WIDTH cycles, LSB first, carry in a flop.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  serial_add_ctrl_if.slave   bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             done_q, done_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_shift;

  full_adder fa (
    .A    (a_sr_q[0]),
    .B    (b_sr_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_co)
  );

  // New sum bit enters at the MSB; works for WIDTH=1
  always_comb begin
    s_shift          = s_sr_q >> 1;
    s_shift[WIDTH-1] = fa_s;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = fa_co;
        s_sr_d  = s_shift;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = s_shift;
          cout_d  = fa_co;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl.
// WIDTH=8 main instance plus a WIDTH=1 instance.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Runs one op on the 8-bit instance and checks timing and result
  task automatic run_op(input string tag,
                        input logic [7:0] av,
                        input logic [7:0] bv,
                        input logic cv,
                        input logic [7:0] es,
                        input logic ec);
    int n;
    int nb;
    logic stable;
    logic [7:0] s0;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.cin = cv;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0; nb = 0; stable = 1'b1; s0 = bus.sum;
    while (!bus.done && n < 30) begin
      if (bus.busy) nb++;
      if (bus.sum !== s0) stable = 1'b0;
      n++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_busy"}, 32'(nb), 32'd8);
    chk({tag, "_hold"}, 32'(stable), 32'd1);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int n;
    int ndone;
    logic ok;
    bus.start = 0; bus.a = '0; bus.b = '0; bus.cin = 0;
    bus1.start = 0; bus1.a = '0; bus1.b = '0; bus1.cin = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'h00);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst1_sum", 32'(bus1.sum), 32'd0);
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 32'd0);

    run_op("basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    run_op("rip1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("rip2", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    run_op("rip3", 8'h80, 8'h80, 1'b1, 8'h01, 1'b1);

    // Operand/start immunity during RUN
    @(negedge clk);
    bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.a = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("imm_done", 32'(bus.done), 32'd1);
    chk("imm_sum", 32'(bus.sum), 32'h10);
    chk("imm_cout", 32'(bus.cout), 32'd0);
    ok = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy || bus.done) ok = 1'b0;
    end
    chk("imm_noop", 32'(ok), 32'd1);

    // Back-to-back with start held high
    bus.a = 8'h01; bus.b = 8'h01; bus.cin = 0;
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < 30) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_first", 32'(bus.done), 32'd1);
    chk("b2b_sum0", 32'(bus.sum), 32'h02);
    for (int p = 0; p < 2; p++) begin
      n = 0; ok = 1'b1;
      @(negedge clk);
      n++;
      while (!bus.done && n < 30) begin
        if (bus.sum !== 8'h02) ok = 1'b0;
        n++;
        @(negedge clk);
      end
      chk("b2b_period", 32'(n), 32'd9);
      chk("b2b_stable", 32'(ok), 32'd1);
      chk("b2b_sum", 32'(bus.sum), 32'h02);
    end
    bus.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("b2b_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of an operation
    bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_done", 32'(bus.done), 32'd0);
    chk("mrst_sum", 32'(bus.sum), 32'h00);
    chk("mrst_cout", 32'(bus.cout), 32'd0);
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("mrst_nodone", 32'(ndone), 32'd0);
    run_op("after", 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0);

    // WIDTH=1 instance
    @(negedge clk);
    bus1.a = 1'b1; bus1.b = 1'b1; bus1.cin = 1'b1;
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    chk("w1_busy", 32'(bus1.busy), 32'd1);
    chk("w1_early", 32'(bus1.done), 32'd0);
    @(negedge clk);
    chk("w1_done", 32'(bus1.done), 32'd1);
    chk("w1_sum", 32'(bus1.sum), 32'd1);
    chk("w1_cout", 32'(bus1.cout), 32'd1);
    chk("w1_idle", 32'(bus1.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
